// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage.
// Optional feature macro used by ex_stage: EX_MUL_EN (iterative multiplier).
package ex_pkg;

  // ALU operation encoding; ALU_ZERO is the flush/bubble default.
  typedef enum logic [3:0] {
    ALU_ZERO  = 4'd0,
    ALU_ADD   = 4'd1,
    ALU_SUB   = 4'd2,
    ALU_AND   = 4'd3,
    ALU_OR    = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SLL   = 4'd6,
    ALU_SRL   = 4'd7,
    ALU_SRA   = 4'd8,
    ALU_ROL   = 4'd9,
    ALU_PASSB = 4'd10,
    ALU_MUL   = 4'd11
  } alu_ops_t;

  // Iterative multiplier state.
  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_BUSY = 1'b1
  } mul_state_t;

  // Bit positions inside ALUSrc.
  localparam int ALUSRC_B_IMM = 0;
  localparam int ALUSRC_A_PC  = 1;

  // Control bits carried through EX/MEM.
  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
    logic mem_write;
    logic mem_read;
    logic mem_size;
  } exmem_ctrl_t;

  // Bubble: no side effects in MEM/WB, MemSize parked at 1.
  localparam exmem_ctrl_t EXMEM_BUBBLE = '{
    mem_to_reg: 1'b0,
    reg_write:  1'b0,
    mem_write:  1'b0,
    mem_read:   1'b0,
    mem_size:   1'b1
  };

endpackage

// File: rtl/ex_alu.sv
// Purely combinational ALU for the execute stage. MUL and ZERO yield 0 here;
// the multiplier result is produced by ex_stage.
module ex_alu
  import ex_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  alu_ops_t              op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  logic [4:0] shamt;
  logic [5:0] rol_rsh;

  assign shamt   = b_i[4:0];
  assign rol_rsh = 6'd32 - {1'b0, shamt};

  // Operation select; rotate by 0 works because a right shift by 32 is 0.
  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:   result_o = a_i + b_i;
      ALU_SUB:   result_o = a_i - b_i;
      ALU_AND:   result_o = a_i & b_i;
      ALU_OR:    result_o = a_i | b_i;
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_SLL:   result_o = a_i << shamt;
      ALU_SRL:   result_o = a_i >> shamt;
      ALU_SRA:   result_o = DATA_WIDTH'($signed(a_i) >>> shamt);
      ALU_ROL:   result_o = (a_i << shamt) | (a_i >> rol_rsh);
      ALU_PASSB: result_o = b_i;
      default:   result_o = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, BEQ branch resolve and the EX/MEM
// register. Define EX_MUL_EN to add a 33-cycle shift-add multiplier that
// holds the front of the pipe through ex_busy.
module ex_stage
  import ex_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            flush_and_stall,
  input  logic                  MemtoReg,
  input  logic                  RegWrite,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic                  MemSize,
  input  logic                  Branch,
  input  alu_ops_t              ALUOp,
  input  logic [1:0]            ALUSrc,
  input  logic [ADDR_WIDTH-1:0] PC_in,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  input  logic [4:0]            waddr,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic                  mem_fwd_we,
  input  logic                  wb_fwd_we,
  input  logic [4:0]            mem_fwd_addr,
  input  logic [4:0]            wb_fwd_addr,
  input  logic [DATA_WIDTH-1:0] mem_fwd_data,
  input  logic [DATA_WIDTH-1:0] wb_fwd_data,
  output logic                  MemtoReg_out,
  output logic                  RegWrite_out,
  output logic                  MemWrite_out,
  output logic                  MemRead_out,
  output logic                  MemSize_out,
  output logic [DATA_WIDTH-1:0] alu_result_out,
  output logic [DATA_WIDTH-1:0] store_data_out,
  output logic [4:0]            waddr_out,
  output logic                  branch_taken,
  output logic [ADDR_WIDTH-1:0] branch_target,
  output logic                  ex_busy
);

  logic                  flush, stall;
  logic [DATA_WIDTH-1:0] fwd_rs1, fwd_rs2, op_a, op_b, alu_res, ex_result;
  exmem_ctrl_t           ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] result_q, result_d, store_q, store_d;
  logic [4:0]            waddr_q, waddr_d;

  assign flush = flush_and_stall[1];
  assign stall = flush_and_stall[0];

  // Forwarding: MEM beats WB beats register file; x0 never forwards.
  always_comb begin
    fwd_rs1 = rs1_data;
    if (wb_fwd_we && wb_fwd_addr == rs1_addr && rs1_addr != 5'd0) fwd_rs1 = wb_fwd_data;
    if (mem_fwd_we && mem_fwd_addr == rs1_addr && rs1_addr != 5'd0) fwd_rs1 = mem_fwd_data;
    fwd_rs2 = rs2_data;
    if (wb_fwd_we && wb_fwd_addr == rs2_addr && rs2_addr != 5'd0) fwd_rs2 = wb_fwd_data;
    if (mem_fwd_we && mem_fwd_addr == rs2_addr && rs2_addr != 5'd0) fwd_rs2 = mem_fwd_data;
  end

  assign op_a = ALUSrc[ALUSRC_A_PC]  ? DATA_WIDTH'(PC_in) : fwd_rs1;
  assign op_b = ALUSrc[ALUSRC_B_IMM] ? imm                : fwd_rs2;

  ex_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op_i     (ALUOp),
    .a_i      (op_a),
    .b_i      (op_b),
    .result_o (alu_res)
  );

  assign branch_target = PC_in + ADDR_WIDTH'(imm);
  assign branch_taken  = Branch && (fwd_rs1 == fwd_rs2) && !ex_busy && !stall;

`ifdef EX_MUL_EN
  mul_state_t            state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d, ma_q, ma_d, mb_q, mb_d;
  logic [DATA_WIDTH-1:0] step_add, product;
  logic                  mul_done;

  // Partial product for the current bit; the last one is folded into the result.
  assign step_add = mb_q[cnt_q] ? (ma_q << cnt_q) : '0;
  assign product  = acc_q + step_add;
  assign mul_done = (state_q == MUL_BUSY) && (cnt_q == 5'd31);
  assign ex_busy  = ((state_q == MUL_IDLE) && (ALUOp == ALU_MUL)) ||
                    ((state_q == MUL_BUSY) && (cnt_q != 5'd31));
  assign ex_result = mul_done ? product : alu_res;

  // Multiplier next state: flush aborts, stall freezes, otherwise advance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    if (flush) begin
      state_d = MUL_IDLE;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (!stall) begin
      case (state_q)
        MUL_IDLE: begin
          if (ALUOp == ALU_MUL) begin
            ma_d    = op_a;
            mb_d    = op_b;
            cnt_d   = '0;
            acc_d   = '0;
            state_d = MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          if (cnt_q == 5'd31) begin
            state_d = MUL_IDLE;
            cnt_d   = '0;
            acc_d   = '0;
          end else begin
            acc_d = product;
            cnt_d = cnt_q + 5'd1;
          end
        end
        default: state_d = MUL_IDLE;
      endcase
    end
  end

  // Multiplier state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
    end
  end
`else
  assign ex_busy   = 1'b0;
  assign ex_result = alu_res;
`endif

  // EX/MEM next value: flush > stall > busy > load.
  always_comb begin
    ctrl_d   = ctrl_q;
    result_d = result_q;
    store_d  = store_q;
    waddr_d  = waddr_q;
    if (flush || (!stall && ex_busy)) begin
      ctrl_d   = EXMEM_BUBBLE;
      result_d = '0;
      store_d  = '0;
      waddr_d  = '0;
    end else if (!stall) begin
      ctrl_d   = '{mem_to_reg: MemtoReg, reg_write: RegWrite, mem_write: MemWrite,
                   mem_read: MemRead, mem_size: MemSize};
      result_d = ex_result;
      store_d  = fwd_rs2;
      waddr_d  = waddr;
    end
  end

  // EX/MEM register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q   <= EXMEM_BUBBLE;
      result_q <= '0;
      store_q  <= '0;
      waddr_q  <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      store_q  <= store_d;
      waddr_q  <= waddr_d;
    end
  end

  assign MemtoReg_out   = ctrl_q.mem_to_reg;
  assign RegWrite_out   = ctrl_q.reg_write;
  assign MemWrite_out   = ctrl_q.mem_write;
  assign MemRead_out    = ctrl_q.mem_read;
  assign MemSize_out    = ctrl_q.mem_size;
  assign alu_result_out = result_q;
  assign store_data_out = store_q;
  assign waddr_out      = waddr_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage (default build, or EX_MUL_EN when defined).
module tb_ex_stage;
  import ex_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic [1:0]  flush_and_stall;
  logic        MemtoReg, RegWrite, MemWrite, MemRead, MemSize, Branch;
  alu_ops_t    ALUOp;
  logic [1:0]  ALUSrc;
  logic [31:0] PC_in, rs1_data, rs2_data, imm, mem_fwd_data, wb_fwd_data;
  logic [4:0]  rs1_addr, rs2_addr, waddr, mem_fwd_addr, wb_fwd_addr;
  logic        mem_fwd_we, wb_fwd_we;
  logic        MemtoReg_out, RegWrite_out, MemWrite_out, MemRead_out, MemSize_out;
  logic [31:0] alu_result_out, store_data_out, branch_target;
  logic [4:0]  waddr_out;
  logic        branch_taken, ex_busy;

  ex_stage dut (
    .clk(clk), .reset_n(reset_n), .flush_and_stall(flush_and_stall),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead),
    .MemSize(MemSize), .Branch(Branch), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .PC_in(PC_in),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .waddr(waddr), .imm(imm), .mem_fwd_we(mem_fwd_we), .wb_fwd_we(wb_fwd_we),
    .mem_fwd_addr(mem_fwd_addr), .wb_fwd_addr(wb_fwd_addr), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_data(wb_fwd_data), .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out),
    .MemWrite_out(MemWrite_out), .MemRead_out(MemRead_out), .MemSize_out(MemSize_out),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out), .waddr_out(waddr_out),
    .branch_taken(branch_taken), .branch_target(branch_target), .ex_busy(ex_busy)
  );

  // ---------------- scoreboard ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_fwd(input logic [4:0] src, input logic [31:0] rf);
    if (src != 0 && mem_fwd_we && mem_fwd_addr == src) return mem_fwd_data;
    if (src != 0 && wb_fwd_we && wb_fwd_addr == src) return wb_fwd_data;
    return rf;
  endfunction

  function automatic logic [31:0] m_alu(input alu_ops_t op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] dbl;
    int sh;
    sh = int'(b % 32);
    case (op)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a + (~b) + 32'd1;
      ALU_AND:   return a & b;
      ALU_OR:    return a | b;
      ALU_XOR:   return a ^ b;
      ALU_SLL:   return a * (32'd1 << sh);
      ALU_SRL:   return a / (32'd1 << sh);
      ALU_SRA:   return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      ALU_ROL: begin
        dbl = {a, a} << sh;
        return dbl[63:32];
      end
      ALU_PASSB: return b;
      default:   return 32'd0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    flush_and_stall = 2'b00;
    {MemtoReg, RegWrite, MemWrite, MemRead, MemSize, Branch} = 6'b0;
    ALUOp = ALU_ZERO; ALUSrc = 2'b00; PC_in = '0; imm = '0;
    rs1_data = '0; rs2_data = '0; rs1_addr = '0; rs2_addr = '0; waddr = '0;
    mem_fwd_we = 0; wb_fwd_we = 0; mem_fwd_addr = '0; wb_fwd_addr = '0;
    mem_fwd_data = '0; wb_fwd_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input alu_ops_t op, input logic [4:0] a1, input logic [31:0] d1,
                          input logic [4:0] a2, input logic [31:0] d2, input logic [4:0] wd);
    ALUOp = op; rs1_addr = a1; rs1_data = d1; rs2_addr = a2; rs2_data = d2;
    waddr = wd; RegWrite = 1'b1; ALUSrc = 2'b00;
  endtask

  alu_ops_t ops[10] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
                        ALU_SLL, ALU_SRL, ALU_SRA, ALU_ROL, ALU_PASSB};

  initial begin
    logic [31:0] ea, eb, exp_st;
    drive_idle();
    reset_n = 1'b0;
    #12;
    check("rst_alu", alu_result_out, 32'd0);
    check("rst_store", store_data_out, 32'd0);
    check("rst_waddr", {27'd0, waddr_out}, 32'd0);
    check("rst_ctrl", {27'd0, MemtoReg_out, RegWrite_out, MemWrite_out, MemRead_out, MemSize_out}, 32'd1);
    check("rst_busy", {31'd0, ex_busy}, 32'd0);
    reset_n = 1'b1;
    step();

    // 1. ADD 5 + 7
    drive_op(ALU_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3);
    step();
    check("add_res", alu_result_out, 32'd12);
    check("add_waddr", {27'd0, waddr_out}, 32'd3);
    check("add_rw", {31'd0, RegWrite_out}, 32'd1);
    check("add_store", store_data_out, 32'd7);

    // 2. Forwarding priority
    drive_op(ALU_ADD, 5'd4, 32'h99, 5'd5, 32'd0, 5'd6);
    mem_fwd_we = 1; mem_fwd_addr = 5'd4; mem_fwd_data = 32'h10;
    wb_fwd_we = 1;  wb_fwd_addr = 5'd4;  wb_fwd_data = 32'h20;
    step();
    check("fwd_mem_wins", alu_result_out, 32'h10);
    mem_fwd_we = 0;
    step();
    check("fwd_wb", alu_result_out, 32'h20);
    mem_fwd_we = 1; mem_fwd_addr = 5'd0; wb_fwd_addr = 5'd0; rs1_addr = 5'd0;
    step();
    check("fwd_x0", alu_result_out, 32'h99);
    rs2_addr = 5'd9; rs2_data = 32'h5; mem_fwd_addr = 5'd9; wb_fwd_addr = 5'd9;
    step();
    check("fwd_store", store_data_out, 32'h10);
    drive_idle();

    // 3. Branch resolve
    Branch = 1; rs1_addr = 5'd1; rs2_addr = 5'd2; rs1_data = 32'd9; rs2_data = 32'd9;
    PC_in = 32'h8000_0010; imm = 32'hFFFF_FFF8;
    #1;
    check("br_taken", {31'd0, branch_taken}, 32'd1);
    check("br_target", branch_target, 32'h8000_0008);
    rs2_data = 32'd10;
    #1;
    check("br_not_taken", {31'd0, branch_taken}, 32'd0);
    wb_fwd_we = 1; wb_fwd_addr = 5'd2; wb_fwd_data = 32'd9;
    #1;
    check("br_fwd_taken", {31'd0, branch_taken}, 32'd1);
    flush_and_stall = 2'b01;
    #1;
    check("br_stalled", {31'd0, branch_taken}, 32'd0);
    drive_idle();
    step();

    // 4. Stall holds, flush bubbles
    drive_op(ALU_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3);
    step();
    flush_and_stall = 2'b01; rs1_data = 32'd100; waddr = 5'd8;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_res", alu_result_out, 32'd12);
      check("stall_waddr", {27'd0, waddr_out}, 32'd3);
    end
    flush_and_stall = 2'b11;
    step();
    check("flush_rw", {31'd0, RegWrite_out}, 32'd0);
    check("flush_size", {31'd0, MemSize_out}, 32'd1);
    check("flush_res", alu_result_out, 32'd0);
    drive_idle();

    // Random ops against the model
    for (int i = 0; i < 60; i++) begin
      ALUOp = ops[$urandom_range(0, 9)];
      ALUSrc = 2'($urandom_range(0, 3));
      rs1_addr = 5'($urandom_range(0, 3)); rs2_addr = 5'($urandom_range(0, 3));
      rs1_data = $urandom; rs2_data = $urandom; imm = $urandom; PC_in = $urandom;
      mem_fwd_we = 1'($urandom_range(0, 1)); wb_fwd_we = 1'($urandom_range(0, 1));
      mem_fwd_addr = 5'($urandom_range(0, 3)); wb_fwd_addr = 5'($urandom_range(0, 3));
      mem_fwd_data = $urandom; wb_fwd_data = $urandom;
      waddr = 5'($urandom_range(0, 31)); RegWrite = 1'($urandom_range(0, 1));
      MemWrite = 1'($urandom_range(0, 1)); MemSize = 1'($urandom_range(0, 1));
      ea = ALUSrc[1] ? PC_in : m_fwd(rs1_addr, rs1_data);
      eb = ALUSrc[0] ? imm : m_fwd(rs2_addr, rs2_data);
      exp_st = m_fwd(rs2_addr, rs2_data);
      exp_q.push_back(m_alu(ALUOp, ea, eb));
      exp_q.push_back(exp_st);
      exp_q.push_back({25'd0, waddr, RegWrite, MemWrite, MemSize});
      step();
      check("rand_res", alu_result_out, exp_q.pop_front());
      check("rand_store", store_data_out, exp_q.pop_front());
      check("rand_ctrl", {25'd0, waddr_out, RegWrite_out, MemWrite_out, MemSize_out}, exp_q.pop_front());
    end
    drive_idle();
    step();

`ifdef EX_MUL_EN
    // 5. MUL 0xFFFFFFFF * 3 with MEM forward draining mid-op
    drive_op(ALU_MUL, 5'd1, 32'd0, 5'd2, 32'd3, 5'd7);
    mem_fwd_we = 1; mem_fwd_addr = 5'd1; mem_fwd_data = 32'hFFFF_FFFF;
    exp_q.push_back(32'hFFFF_FFFF * 32'd3);
    #1;
    check("mul_busy_start", {31'd0, ex_busy}, 32'd1);
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 1) mem_fwd_data = 32'd0;
      check("mul_bubble", {31'd0, RegWrite_out}, 32'd0);
      check("mul_busy", {31'd0, ex_busy}, (k < 32) ? 32'd1 : 32'd0);
    end
    step();
    check("mul_res", alu_result_out, exp_q.pop_front());
    check("mul_rw", {31'd0, RegWrite_out}, 32'd1);
    check("mul_waddr", {27'd0, waddr_out}, 32'd7);
    drive_idle();
    step();

    // 6a. Reset mid-multiply
    drive_op(ALU_MUL, 5'd1, 32'd1234, 5'd2, 32'd77, 5'd5);
    for (int k = 0; k < 11; k++) step();
    reset_n = 1'b0;
    drive_idle();
    #1;
    check("mrst_busy", {31'd0, ex_busy}, 32'd0);
    check("mrst_res", alu_result_out, 32'd0);
    check("mrst_ctrl", {27'd0, MemtoReg_out, RegWrite_out, MemWrite_out, MemRead_out, MemSize_out}, 32'd1);
    #3 reset_n = 1'b1;
    step();

    // 6b. Flush mid-multiply aborts with no writeback
    drive_op(ALU_MUL, 5'd1, 32'd1234, 5'd2, 32'd77, 5'd5);
    for (int k = 0; k < 6; k++) step();
    flush_and_stall = 2'b10;
    step();
    drive_idle();
    #1;
    check("mflush_busy", {31'd0, ex_busy}, 32'd0);
    for (int k = 0; k < 35; k++) begin
      step();
      check("mflush_norw", {31'd0, RegWrite_out}, 32'd0);
    end
`else
    // MUL without the multiplier: 0 in one cycle, never busy
    drive_op(ALU_MUL, 5'd1, 32'd6, 5'd2, 32'd7, 5'd4);
    #1;
    check("mul_off_busy", {31'd0, ex_busy}, 32'd0);
    step();
    check("mul_off_res", alu_result_out, 32'd0);
    check("mul_off_rw", {31'd0, RegWrite_out}, 32'd1);
    drive_idle();
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
